mem_stage: RTL and testbench

//   Memory stage directly downstream of the ALU compute block. Accepts one EX

---
 rtl/mem_stage.sv | 202 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage downstream of the ALU. ALU results retire to write-back in one
// cycle; LW/SW run a req/ack transaction on the data memory and stall upstream
// until ack or timeout abort. HLT retires once and freezes the stage until reset.
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_result,
    input  logic [3:0]  ex_dst_reg,
    input  logic        ex_wr_en,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_dst_reg,
    output logic        wb_wr_en,
    output logic        wb_halt,
    output logic        mem_err
);

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Counter value on the last BUSY cycle allowed before the abort edge.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_is_hlt;
    logic        w_ack_done;
    logic        w_timeout;

    logic [7:0]  r_cnt;
    logic        r_cap_is_sw;
    logic        r_cap_wr_en;
    logic [3:0]  r_cap_dst;

    logic        r_mem_req;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;

    logic        r_wb_valid;
    logic [15:0] r_wb_data;
    logic [3:0]  r_wb_dst_reg;
    logic        r_wb_wr_en;
    logic        r_wb_halt;
    logic        r_mem_err;

    // Only IDLE accepts; held low while reset is asserted.
    assign ex_ready = (r_state == ST_IDLE) & rst_n;

    // Next-state decode plus the per-cycle event strobes used by the datapath.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        w_is_mem     = (ex_opcode == OP_LW) || (ex_opcode == OP_SW);
        w_is_hlt     = (ex_opcode == OP_HLT);
        case (r_state)
            ST_IDLE: begin
                w_accept = ex_valid;
                if (w_accept) begin
                    if (w_is_mem) begin
                        w_state_next = ST_BUSY;
                    end else if (w_is_hlt) begin
                        w_state_next = ST_HALTED;
                    end
                end
            end
            ST_BUSY: begin
                // An ack in the final allowed cycle beats the timeout.
                w_ack_done = mem_ack;
                w_timeout  = !mem_ack && (r_cnt == CNT_LAST);
                if (w_ack_done || w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: capture on accept, run the memory handshake, fill the write-back slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 8'd0;
            r_cap_is_sw  <= 1'b0;
            r_cap_wr_en  <= 1'b0;
            r_cap_dst    <= 4'd0;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= 16'd0;
            r_mem_wdata  <= 16'd0;
            r_wb_valid   <= 1'b0;
            r_wb_data    <= 16'd0;
            r_wb_dst_reg <= 4'd0;
            r_wb_wr_en   <= 1'b0;
            r_wb_halt    <= 1'b0;
            r_mem_err    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem) begin
                            r_cnt       <= 8'd0;
                            r_cap_is_sw <= (ex_opcode == OP_SW);
                            r_cap_wr_en <= ex_wr_en;
                            r_cap_dst   <= ex_dst_reg;
                            r_mem_req   <= 1'b1;
                            r_mem_wr    <= (ex_opcode == OP_SW);
                            r_mem_addr  <= ex_addr & 16'hFFFE;
                            r_mem_wdata <= ex_result;
                        end else if (w_is_hlt) begin
                            r_wb_valid   <= 1'b1;
                            r_wb_halt    <= 1'b1;
                            r_wb_wr_en   <= 1'b0;
                            r_wb_dst_reg <= ex_dst_reg;
                        end else begin
                            r_wb_valid   <= 1'b1;
                            r_wb_data    <= ex_result;
                            r_wb_dst_reg <= ex_dst_reg;
                            r_wb_wr_en   <= ex_wr_en;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_ack_done) begin
                        r_mem_req    <= 1'b0;
                        r_wb_valid   <= 1'b1;
                        r_wb_dst_reg <= r_cap_dst;
                        if (r_cap_is_sw) begin
                            r_wb_data  <= r_mem_wdata;
                            r_wb_wr_en <= 1'b0;
                        end else begin
                            r_wb_data  <= mem_rdata;
                            r_wb_wr_en <= r_cap_wr_en;
                        end
                    end else if (w_timeout) begin
                        r_mem_req    <= 1'b0;
                        r_mem_err    <= 1'b1;
                        r_wb_valid   <= 1'b1;
                        r_wb_data    <= 16'd0;
                        r_wb_wr_en   <= 1'b0;
                        r_wb_dst_reg <= r_cap_dst;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    // HALTED: everything frozen, wb_halt stays set.
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_data    = r_wb_data;
    assign wb_dst_reg = r_wb_dst_reg;
    assign wb_wr_en   = r_wb_wr_en & r_wb_valid;
    assign wb_halt    = r_wb_halt;
    assign mem_err    = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes expected write-back records
// computed from an architectural memory model; a monitor pops and compares them,
// and a memory responder process plays the data RAM with programmable wait.
module tb_mem_stage;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [3:0]  ex_opcode = 4'd0;
    logic [15:0] ex_addr = 16'd0;
    logic [15:0] ex_result = 16'd0;
    logic [3:0]  ex_dst_reg = 4'd0;
    logic        ex_wr_en = 1'b0;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [3:0]  wb_dst_reg;
    logic        wb_wr_en;
    logic        wb_halt;
    logic        mem_err;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
        .ex_addr(ex_addr), .ex_result(ex_result), .ex_dst_reg(ex_dst_reg),
        .ex_wr_en(ex_wr_en),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_dst_reg(wb_dst_reg),
        .wb_wr_en(wb_wr_en), .wb_halt(wb_halt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dst;
        logic        wr_en;
        logic        halt;
        logic        err;
        logic        chk_data;
        logic        chk_dst;
    } wb_t;

    wb_t         exp_q[$];
    wb_t         mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] ext_mem   [0:32767];
    logic [15:0] model_mem [0:32767];
    logic        model_err = 1'b0;
    int          ack_wait = 255;
    int          req_cycles = 0;
    logic [15:0] exp_maddr = 16'd0;
    logic [15:0] exp_mwdata = 16'd0;
    logic        exp_mwr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write-back must match the oldest expected record.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_wb: got wb_data %0h, expected no write-back", wb_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("[TB] wb data=%h dst=%0d wr=%0b halt=%0b err=%0b",
                             wb_data, wb_dst_reg, wb_wr_en, wb_halt, mem_err);
                    if (mon_e.chk_data) chk("wb_data", 32'(wb_data), 32'(mon_e.data));
                    if (mon_e.chk_dst) chk("wb_dst_reg", 32'(wb_dst_reg), 32'(mon_e.dst));
                    chk("wb_wr_en", 32'(wb_wr_en), 32'(mon_e.wr_en));
                    chk("wb_halt", 32'(wb_halt), 32'(mon_e.halt));
                    chk("mem_err", 32'(mem_err), 32'(mon_e.err));
                end
            end else begin
                chk("wb_wr_en_idle", 32'(wb_wr_en), 32'd0);
            end
        end
    end

    // Data memory: acks after ack_wait wait cycles, junk rdata otherwise,
    // and spurious acks while no request is outstanding.
    always @(negedge clk) begin
        if (!rst_n) begin
            req_cycles = 0;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            req_cycles++;
            chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
            chk("mem_wr", 32'(mem_wr), 32'(exp_mwr));
            chk("mem_wdata", 32'(mem_wdata), 32'(exp_mwdata));
            if (req_cycles == ack_wait + 1) begin
                mem_ack = 1'b1;
                if (mem_wr) ext_mem[mem_addr[15:1]] = mem_wdata;
                mem_rdata = ext_mem[mem_addr[15:1]];
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end else begin
            req_cycles = 0;
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end
    end

    task automatic drive_alu(input logic [3:0] op, input logic [15:0] res,
                             input logic [3:0] dst, input logic wr);
        wb_t e;
        @(negedge clk);
        chk("ex_ready_issue", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_opcode = op; ex_addr = 16'($urandom);
        ex_result = res; ex_dst_reg = dst; ex_wr_en = wr;
        e.data = res; e.dst = dst; e.wr_en = wr; e.halt = 1'b0;
        e.err = model_err; e.chk_data = 1'b1; e.chk_dst = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic drive_halt();
        wb_t e;
        @(negedge clk);
        chk("ex_ready_issue", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_opcode = 4'b1111; ex_addr = 16'($urandom);
        ex_result = 16'($urandom); ex_dst_reg = 4'($urandom); ex_wr_en = 1'b1;
        e.data = 16'd0; e.dst = 4'd0; e.wr_en = 1'b0; e.halt = 1'b1;
        e.err = model_err; e.chk_data = 1'b0; e.chk_dst = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic bubble();
        @(negedge clk);
        ex_valid = 1'b0; ex_opcode = 4'($urandom); ex_result = 16'($urandom);
        ex_wr_en = 1'b1;
    endtask

    task automatic drive_mem(input logic is_sw, input logic [15:0] addr, input logic [15:0] data,
                             input logic [3:0] dst, input logic wr, input int wait_cyc);
        wb_t e;
        int n;
        int exp_low;
        @(negedge clk);
        chk("ex_ready_issue", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_opcode = is_sw ? 4'b1001 : 4'b1000; ex_addr = addr;
        ex_result = data; ex_dst_reg = dst; ex_wr_en = wr;
        exp_maddr = {addr[15:1], 1'b0}; exp_mwr = is_sw; exp_mwdata = data;
        ack_wait = wait_cyc;
        e.dst = dst; e.halt = 1'b0; e.chk_data = 1'b1; e.chk_dst = 1'b1;
        if (wait_cyc < TO) begin
            if (is_sw) begin
                model_mem[addr[15:1]] = data;
                e.data = data; e.wr_en = 1'b0;
            end else begin
                e.data = model_mem[addr[15:1]]; e.wr_en = wr;
            end
            exp_low = wait_cyc + 1;
        end else begin
            model_err = 1'b1;
            e.data = 16'd0; e.wr_en = 1'b0; e.chk_dst = 1'b0;
            exp_low = TO;
        end
        e.err = model_err;
        exp_q.push_back(e);
        @(negedge clk);
        ex_valid = 1'b0; ex_opcode = 4'($urandom); ex_result = 16'($urandom);
        n = 0;
        while (!ex_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 32'(exp_low));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int w;
        logic [3:0] op;
        int n;
        for (int i = 0; i < 32768; i++) begin
            ext_mem[i]   = 16'(i * 7 + 3);
            model_mem[i] = 16'(i * 7 + 3);
        end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_halt", 32'(wb_halt), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(ex_ready), 32'd1);

        // ALU op: one-cycle latency.
        drive_alu(4'h0, 16'h1234, 4'd3, 1'b1);
        bubble();
        chk("alu_latency_valid", 32'(wb_valid), 32'd1);
        chk("alu_latency_data", 32'(wb_data), 32'h1234);

        // SW BEEF to 0x0040, then LW from 0x0041 with two wait cycles.
        drive_mem(1'b1, 16'h0040, 16'hBEEF, 4'd2, 1'b1, 0);
        drive_mem(1'b0, 16'h0041, 16'h5555, 4'd5, 1'b1, 2);
        chk("lw_beef", 32'(wb_data), 32'hBEEF);
        drive_mem(1'b1, 16'h0010, 16'h00AA, 4'd6, 1'b1, 0);
        // Ack in the final allowed cycle wins over the timeout.
        drive_mem(1'b0, 16'h0100, 16'h0000, 4'd7, 1'b1, TO - 1);
        chk("ack_wins_no_err", 32'(mem_err), 32'd0);
        // Never acked: abort after TIMEOUT busy cycles, sticky error.
        drive_mem(1'b0, 16'h0102, 16'h0000, 4'd7, 1'b1, 255);
        chk("timeout_err", 32'(mem_err), 32'd1);

        // Randomized mix.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                op = 4'($urandom_range(0, 14));
                if (op == 4'b1000 || op == 4'b1001) op = 4'b0101;
                drive_alu(op, 16'($urandom), 4'($urandom), 1'($urandom));
            end else if (r == 5) begin
                bubble();
            end else begin
                w = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
                drive_mem((r == 8), 16'h0100 + 16'($urandom_range(0, 31)), 16'($urandom),
                          4'($urandom), 1'($urandom), w);
            end
        end
        bubble();
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        // Reset pulse while BUSY.
        @(negedge clk);
        ex_valid = 1'b1; ex_opcode = 4'b1000; ex_addr = 16'h0104; ex_result = 16'd0;
        ex_dst_reg = 4'd1; ex_wr_en = 1'b1;
        exp_maddr = 16'h0104; exp_mwr = 1'b0; exp_mwdata = 16'd0; ack_wait = 255;
        @(negedge clk);
        ex_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_before_reset", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("async_rst_mem_err", 32'(mem_err), 32'd0);
        chk("async_rst_wb_wr_en", 32'(wb_wr_en), 32'd0);
        exp_q.delete();
        model_err = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midrst", 32'(ex_ready), 32'd1);
        chk("idle_after_midrst", 32'(mem_req), 32'd0);

        // XOR, HLT, ADD streamed: ADD must never be accepted.
        drive_alu(4'h6, 16'hA5A5, 4'd1, 1'b1);
        drive_halt();
        @(negedge clk);
        ex_valid = 1'b1; ex_opcode = 4'h0; ex_result = 16'h7777; ex_dst_reg = 4'd2; ex_wr_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("halted_ready", 32'(ex_ready), 32'd0);
            chk("halted_flag", 32'(wb_halt), 32'd1);
            @(negedge clk);
        end
        chk("halt_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
